lifo_arbiter: RTL and testbench



---
 rtl/lifo_arbiter.sv | 134 +++++++++++++
 tb/tb_lifo_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
`timescale 1ns/1ps
// lifo_arbiter: two requesters share one 8-deep LIFO through a req/ack handshake; full/empty rejects return an error ack.
// Latency from the sampling IDLE cycle: push ack +2, pop ack +3, error ack +1.
// Backpressure: one request is in flight at a time; the loser holds req until it is granted.
// Optional feature: define LIFO_ARB_RR_EN for round-robin tie-break (default is fixed priority, requester 0 wins).
module lifo_arbiter #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          op0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          op1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          lifo_wn,
  output logic          lifo_rn,
  output logic [DW-1:0] lifo_din,
  input  logic [DW-1:0] lifo_dout,
  input  logic          lifo_full,
  input  logic          lifo_empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;      // granted requester id
  logic          op_q, op_d;        // 1 = push, 0 = pop
  logic          err_q, err_d;      // request rejected on full/empty
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick;              // requester that wins arbitration this cycle
  logic          take;              // a request is accepted this cycle

  assign take = (state_q == S_IDLE) && (req0 || req1);

`ifdef LIFO_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin pick: on a tie the requester not granted last time wins
  always_comb begin
    pick   = (req0 && req1) ? ~last_q : ~req0;
    last_d = take ? pick : last_q;
  end

  // Last-grant pointer; resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // Fixed priority pick: requester 0 always wins a tie
  always_comb begin
    pick = ~req0;
  end
`endif

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state; rejected requests skip straight to ACK with no strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = err_d ? S_ACK : S_ISSUE;
      S_ISSUE: state_d = op_q ? S_ACK : S_WAIT;
      S_WAIT:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch on grant, full/empty check, and popped-data capture in WAIT
  always_comb begin
    gnt_d   = gnt_q;
    op_d    = op_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (take) begin
      gnt_d   = pick;
      op_d    = pick ? op1 : op0;
      wdata_d = pick ? wdata1 : wdata0;
      err_d   = op_d ? lifo_full : lifo_empty;
    end
    if (state_q == S_WAIT) rdata_d = lifo_dout;
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from registered state so reset forces them low at once
  always_comb begin
    busy     = (state_q != S_IDLE);
    ack0     = (state_q == S_ACK) && !gnt_q;
    ack1     = (state_q == S_ACK) &&  gnt_q;
    err0     = ack0 && err_q;
    err1     = ack1 && err_q;
    lifo_wn  = (state_q == S_ISSUE) &&  op_q;
    lifo_rn  = (state_q == S_ISSUE) && !op_q;
    lifo_din = lifo_wn ? wdata_q : '0;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
`timescale 1ns/1ps
// tb_lifo_arbiter: randomized and directed requests against a queue-based reference of the shared stack.
// Latency: checks ack arrival cycle per request kind against the sampling IDLE cycle.
// Backpressure: contention case holds both requests high and checks grant order.
module tb_lifo_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, op0, req1, op1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, err0, ack1, err1, busy, lifo_wn, lifo_rn;
  logic [7:0] rdata, lifo_din, lifo_dout;
  logic       lifo_full, lifo_empty;

  int n_vec = 0;
  int n_err = 0;

  lifo_arbiter #(.DW(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
    .rdata(rdata), .busy(busy),
    .lifo_wn(lifo_wn), .lifo_rn(lifo_rn), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
  );

  always #5 clock = ~clock;

  // Behavioural 8-deep stack attached to the DUT; not cleared by the arbiter reset
  logic [7:0] stk [8];
  logic [3:0] stk_n    = 4'd0;
  logic [7:0] dout_r   = 8'h00;
  logic [7:0] last_din = 8'h00;
  int         wn_tot   = 0;
  int         rn_tot   = 0;

  always @(posedge clock) begin
    if (lifo_wn) begin
      wn_tot   <= wn_tot + 1;
      last_din <= lifo_din;
      if (stk_n < 4'd8) begin
        stk[stk_n[2:0]] <= lifo_din;
        stk_n <= stk_n + 4'd1;
      end
    end
    if (lifo_rn) begin
      rn_tot <= rn_tot + 1;
      if (stk_n != 4'd0) begin
        dout_r <= stk[stk_n[2:0] - 3'd1];
        stk_n  <= stk_n - 4'd1;
      end
    end
  end

  assign lifo_dout  = dout_r;
  assign lifo_full  = (stk_n == 4'd8);
  assign lifo_empty = (stk_n == 4'd0);

  // Reference: stack contents, last popped value, last granted requester
  logic [7:0] ref_q [$];
  logic [7:0] ref_rdata = 8'h00;
  bit         ref_last  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one request from a single requester, starting in an IDLE cycle
  task automatic run_single(input bit id, input bit op, input logic [7:0] d);
    bit exp_err, done, other_seen;
    int exp_lat, cyc, wn0, rn0;
    exp_err = op ? (ref_q.size() >= 8) : (ref_q.size() == 0);
    exp_lat = exp_err ? 1 : (op ? 2 : 3);
    if (!exp_err) begin
      if (op) ref_q.push_back(d);
      else    ref_rdata = ref_q.pop_back();
    end
    ref_last = id;
    wn0 = wn_tot;
    rn0 = rn_tot;
    if (id) begin req1 = 1'b1; op1 = op; wdata1 = d; end
    else    begin req0 = 1'b1; op0 = op; wdata0 = d; end
    cyc = 0; done = 1'b0; other_seen = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
      if (id ? ack0 : ack1) other_seen = 1'b1;
      if (id ? ack1 : ack0) begin
        done = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("err", id ? err1 : err0, exp_err);
        chk("rdata", rdata, ref_rdata);
        chk("busy_in_ack", busy, 1);
      end
    end
    chk("ack_seen", done, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    chk("other_ack", other_seen, 0);
    @(posedge clock); #1;
    chk("wn_count", wn_tot - wn0, (op && !exp_err) ? 1 : 0);
    chk("rn_count", rn_tot - rn0, (!op && !exp_err) ? 1 : 0);
    if (op && !exp_err) chk("lifo_din", last_din, d);
  endtask

  initial begin
    bit   exp_w, exp_err;
    int   grants, cyc;
    logic [7:0] pushes [3];
    reset = 1'b1;
    req0 = 1'b0; op0 = 1'b0; wdata0 = 8'h00;
    req1 = 1'b0; op1 = 1'b0; wdata1 = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack0, ack1, err0, err1}, 0);
    chk("rst_strobe", {lifo_wn, lifo_rn}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_din", lifo_din, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Push A5 then pop it back
    run_single(1'b0, 1'b1, 8'hA5);
    run_single(1'b0, 1'b0, 8'h00);

    // LIFO order from requester 1
    pushes[0] = 8'h11; pushes[1] = 8'h22; pushes[2] = 8'h33;
    for (int i = 0; i < 3; i++) run_single(1'b1, 1'b1, pushes[i]);
    for (int i = 0; i < 3; i++) run_single(1'b1, 1'b0, 8'h00);

    // Empty reject, fill to full, full reject
    run_single(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) run_single(i[0], 1'b1, 8'h40 + 8'(i));
    run_single(1'b0, 1'b1, 8'hEE);
    for (int i = 0; i < 8; i++) run_single(1'b1, 1'b0, 8'h00);

    // Contention: both push continuously for 4 grants
    req0 = 1'b1; op0 = 1'b1; wdata0 = 8'hC0;
    req1 = 1'b1; op1 = 1'b1; wdata1 = 8'hC1;
    grants = 0; cyc = 0;
    while (grants < 4 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0 || ack1) begin
`ifdef LIFO_ARB_RR_EN
        exp_w = !ref_last;
`else
        exp_w = 1'b0;
`endif
        exp_err = (ref_q.size() >= 8);
        chk("grant_id", {ack1, ack0}, exp_w ? 2 : 1);
        chk("grant_err", ack1 ? err1 : err0, exp_err);
        if (!exp_err) ref_q.push_back(exp_w ? 8'hC1 : 8'hC0);
        ref_last = exp_w;
        grants++;
        if (grants == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("grants_done", grants, 4);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;

    // Reset in WAIT of a pop: strobe already landed, no ack, outputs cleared
    req1 = 1'b1; op1 = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("in_wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    void'(ref_q.pop_back());
    ref_rdata = 8'h00;
    ref_last  = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", {ack0, ack1, err0, err1}, 0);
    chk("midrst_rdata", rdata, 0);
    req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("midrst_hold", {ack0, ack1, busy, lifo_rn}, 0);
    end
    reset = 1'b0;
    run_single(1'b1, 1'b0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      run_single(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
